autobaud_detect: RTL and testbench
==================================

# autobaud_detect

Measures the bit period of an incoming UART sync character (0x55) in reference-clock cycles and outputs the matching 32-bit divide ratio for the UART clock divider. This is the receive-side counterpart of the divider: the divider turns a ratio into a clock, and this block turns an observed line rate back into a ratio. It sits in the UART subsystem between the raw RX pin and the divider's ratio input. Software or the APB register block arms it; results are exported as a ratio plus a one-cycle valid or error strobe.

## Interface
- CNT_W, 24: width of the interval and total cycle counters; sets the measurement timeout.
- TOL_SHIFT, 2: interval tolerance is reference >> TOL_SHIFT (±25% by default).
- i_ref_clk  input  1  single clock for the whole block.
- i_rst  input  1  reset, synchronous, active-high.
- i_start  input  1  one-cycle arm request; ignored unless the state is IDLE.
- i_rx  input  1  asynchronous serial line, idle high.
- o_div_ratio  output  32  last successfully measured ratio; reset value 0.
- o_valid  output  1  one-cycle pulse when o_div_ratio updates; reset value 0.
- o_error  output  1  one-cycle pulse on measurement failure; reset value 0.
- o_busy  output  1  high in ARMED and MEASURE; reset value 0.

## Operation
- i_rx passes through a 2-flop synchronizer, reset to 1. A third flop gives the previous value. A falling edge is prev=1 and sync=0.
- 0x55 framed LSB-first gives 5 falling edges: start, d1, d3, d5, d7. These are spaced 2 bit times apart and span 8 bit times.
- State IDLE: o_busy=0. On i_start, go to ARMED.
- State ARMED: wait for a falling edge. On the edge, clear interval_cnt and total_cnt, set edge_idx=1, and go to MEASURE.
- State MEASURE: interval_cnt and total_cnt both increment every cycle. On each falling edge:
  - edge_idx=2: latch ref_int = interval_cnt+1.
  - edge_idx 3–5: error if interval_cnt+1 falls outside [ref_int − (ref_int>>TOL_SHIFT), ref_int + (ref_int>>TOL_SHIFT)].
  - After the check, interval_cnt clears and edge_idx increments.
- At the 5th edge: total = total_cnt+1 and ratio = (total + 4) >> 3, i.e. rounded to nearest, zero-extended to 32 bits.
  - ratio < 2 → error, because the divider treats 0 and 1 as bypass.
  - Otherwise o_div_ratio ← ratio and o_valid pulses.
  - Either way, return to IDLE.
- Timeout: if total_cnt reaches 2^CNT_W−1 in MEASURE, raise error and return to IDLE.
- On any error: o_error pulses, o_div_ratio is unchanged, state returns to IDLE.
- i_start in ARMED or MEASURE is ignored and does not restart the measurement.
- Rising edges are not used for measurement. The stop bit is not checked.

## Timing
- i_rx to detected edge: 2 cycles through the synchronizer plus 1 cycle of edge registration.
- 5th falling edge detected in cycle N → o_valid or o_error high in cycle N+1, with o_div_ratio already updated in N+1. o_busy drops in N+1.
- i_start in cycle N → o_busy high in N+1.
- o_valid and o_error are never high together. Each is high for exactly one cycle.
- i_rst at any cycle, including mid-MEASURE:
  - Next cycle: IDLE, all outputs at reset values, counters 0, synchronizer flops 1.
  - No strobe is emitted for the aborted measurement.
- If the line is low when armed, measurement waits for a genuine 1→0 transition; no edge is inferred from the initial level.

## Structure
- Package uart_pkg:
  - state enum IDLE/ARMED/MEASURE
  - SYNC_EDGES = 5
  - SYNC_BITS_LOG2 = 3
  - MIN_RATIO = 2
- One sub-module is natural: rx_sync_edge, the 2-flop synchronizer plus falling-edge detector. The divider and future RX logic can reuse it.
- Everything else stays in autobaud_detect, an estimated 150–250 lines.

## Test plan
- Arm, then drive 0x55 at 16 cycles/bit → total 128, o_div_ratio=16, o_valid pulses once, o_error stays 0.
- Drive 0x55 with bit periods alternating 10/11 cycles → total 84, ratio (84+4)>>3 = 11, o_valid.
- Make the d3 interval twice the reference (16 vs 32 cycles at 8 cycles/bit) → o_error at the 4th edge, o_div_ratio keeps its prior value.
- Arm, send a start bit, then hold i_rx low with CNT_W=8 → o_error exactly when total_cnt hits 255, followed by IDLE.
- Use 1 cycle/bit (total ≤ 11 → ratio 1) → o_error (ratio < MIN_RATIO).
- Assert i_rst after the 3rd edge → no strobe, o_busy=0 next cycle; a fresh arm plus 0x55 at 16 cycles/bit gives 16. Also: i_start pulsed mid-MEASURE has no effect on the result.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART subsystem types and constants.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

  localparam int SYNC_EDGES     = 5;  // falling edges in a framed 0x55
  localparam int SYNC_BITS_LOG2 = 3;  // edges span 8 bit times
  localparam int MIN_RATIO      = 2;  // divider bypasses ratios 0 and 1
endpackage

// File: rtl/autobaud_detect_rx_sync_edge.sv
// Two-flop synchronizer for an async serial line plus a registered
// falling-edge strobe. Flops reset to the idle-high line level.
module rx_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  output logic o_fall
);
  logic r_s1, r_s2, r_prev, r_fall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_prev <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_rx;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      r_fall <= r_prev & ~r_s2;
    end
  end

  assign o_fall = r_fall;
endmodule

// File: rtl/autobaud_detect.sv
// Measures the bit period of a 0x55 sync character and reports the
// rounded divide ratio (cycles per bit) for the UART clock divider.
module autobaud_detect
  import uart_pkg::*;
#(
  parameter int CNT_W     = 24,
  parameter int TOL_SHIFT = 2
) (
  input  logic        i_ref_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_rx,
  output logic [31:0] o_div_ratio,
  output logic        o_valid,
  output logic        o_error,
  output logic        o_busy
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_int_cnt, r_total_cnt, r_ref_int;
  logic [2:0]        r_edge_idx;
  logic [31:0]       r_ratio;
  logic              r_valid, r_error;

  logic              w_fall, w_ok, w_err, w_in_tol;
  logic [CNT_W:0]    w_intv, w_tol, w_lo, w_hi;
  logic [31:0]       w_total, w_ratio;

  rx_sync_edge u_sync (
    .i_clk  (i_ref_clk),
    .i_rst  (i_rst),
    .i_rx   (i_rx),
    .o_fall (w_fall)
  );

  // Interval just closed by this edge, and its tolerance window.
  assign w_intv   = {1'b0, r_int_cnt} + (CNT_W+1)'(1);
  assign w_tol    = {1'b0, r_ref_int >> TOL_SHIFT};
  assign w_lo     = {1'b0, r_ref_int} - w_tol;
  assign w_hi     = {1'b0, r_ref_int} + w_tol;
  assign w_in_tol = (w_intv >= w_lo) && (w_intv <= w_hi);

  assign w_total  = 32'(r_total_cnt) + 32'd1;
  assign w_ratio  = (w_total + 32'd4) >> SYNC_BITS_LOG2;

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // r_edge_idx counts edges already seen, so the edge being handled is r_edge_idx+1.
  always_comb begin
    w_state_nxt = r_state;
    w_ok        = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE:  if (i_start) w_state_nxt = ARMED;
      ARMED: if (w_fall)  w_state_nxt = MEASURE;
      MEASURE: begin
        if (r_total_cnt == CNT_MAX) begin
          w_err       = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_fall) begin
          if (r_edge_idx >= 3'd2 && !w_in_tol) begin
            w_err       = 1'b1;
            w_state_nxt = IDLE;
          end else if (r_edge_idx == 3'(SYNC_EDGES-1)) begin
            if (w_ratio < 32'(MIN_RATIO)) w_err = 1'b1;
            else                          w_ok  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      r_int_cnt   <= '0;
      r_total_cnt <= '0;
      r_ref_int   <= '0;
      r_edge_idx  <= '0;
      r_ratio     <= '0;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_valid <= w_ok;
      r_error <= w_err;
      if (w_ok) r_ratio <= w_ratio;
      case (r_state)
        ARMED: if (w_fall) begin
          r_int_cnt   <= '0;
          r_total_cnt <= '0;
          r_edge_idx  <= 3'd1;
        end
        MEASURE: begin
          r_int_cnt   <= r_int_cnt + 1'b1;
          r_total_cnt <= r_total_cnt + 1'b1;
          if (w_fall) begin
            if (r_edge_idx == 3'd1) r_ref_int <= w_intv[CNT_W-1:0];
            r_int_cnt  <= '0;
            r_edge_idx <= r_edge_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_div_ratio = r_ratio;
  assign o_valid     = r_valid;
  assign o_error     = r_error;
  assign o_busy      = (r_state != IDLE);
endmodule

// File: tb/tb_autobaud_detect.sv
// Bench for autobaud_detect: table of sync-frame shapes plus hand-written
// timeout, low-line arm, mid-measure reset and re-arm sequences.
module tb_autobaud_detect;
  localparam int CNT_W = 8;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, rx = 1'b1;
  logic [31:0] div_ratio;
  logic        valid, error, busy;

  autobaud_detect #(.CNT_W(CNT_W), .TOL_SHIFT(2)) dut (
    .i_ref_clk   (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_rx        (rx),
    .o_div_ratio (div_ratio),
    .o_valid     (valid),
    .o_error     (error),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  // p: base cycles/bit, alt: added to odd bits, sbit/sext: one bit stretched by sext
  typedef struct { int p; int alt; int sbit; int sext; } vec_t;
  typedef struct { logic err; logic [31:0] ratio; } exp_t;

  exp_t        sb[$];
  int          errors = 0, checks = 0;
  logic [31:0] last_ratio = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && (valid || error)) begin
      chk("strobe_exclusive", {31'b0, valid & error}, 32'd0);
      if (sb.size() == 0) chk("unexpected_strobe", sb.size(), 32'd1);
      else begin
        e = sb.pop_front();
        chk("strobe_is_error", {31'b0, error}, {31'b0, e.err});
        chk("div_ratio", div_ratio, e.ratio);
      end
    end
  end

  function automatic int per_of(vec_t v, int i);
    return v.p + ((i % 2) ? v.alt : 0) + ((i == v.sbit) ? v.sext : 0);
  endfunction

  function automatic exp_t model(vec_t v, logic [31:0] prev);
    int   iv[4];
    int   tot, ref_i, tol, r;
    exp_t e;
    tot = 0;
    for (int k = 0; k < 4; k++) begin
      iv[k] = per_of(v, 2*k) + per_of(v, 2*k+1);
      tot += iv[k];
    end
    ref_i = iv[0];
    tol   = ref_i >> 2;
    e.err = 1'b0;
    for (int k = 1; k < 4; k++)
      if (iv[k] < ref_i - tol || iv[k] > ref_i + tol) e.err = 1'b1;
    r = (tot + 4) >> 3;
    if (r < 2) e.err = 1'b1;
    e.ratio = e.err ? prev : 32'(r);
    return e;
  endfunction

  task automatic arm();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic send_bits(input vec_t v, input int nbits);
    logic [9:0] fr;
    fr = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = fr[i];
      repeat (per_of(v, i)) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clk);
    chk(name, sb.size(), 32'd0);
    sb.delete();
    @(negedge clk);
    chk({name, "_busy_low"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    e = model(v, last_ratio);
    sb.push_back(e);
    if (!e.err) last_ratio = e.ratio;
    arm();
    send_bits(v, 10);
    repeat (4) @(posedge clk);
    drain("vec_drain");
  endtask

  vec_t tbl[11];
  exp_t te;
  int   n;

  initial begin
    tbl = '{'{16, 0, -1,  0},   // 128 cycles -> 16
            '{10, 1, -1,  0},   // 84 -> 11
            '{ 8, 0,  4, 16},   // interval doubled -> error
            '{ 1, 0, -1,  0},   // ratio 1 -> error
            '{ 2, 0, -1,  0},   // ratio 2, smallest legal
            '{ 2, 1, -1,  0},   // 20 -> rounds up to 3
            '{ 8, 0,  4,  4},   // interval 20, upper tolerance edge
            '{ 8, 0,  4,  5},   // interval 21, just outside
            '{ 8, 0,  4, -4},   // interval 12, lower tolerance edge
            '{ 8, 0,  4, -5},   // interval 11, just outside
            '{30, 0, -1,  0}};  // 240 -> 30, close to the 8-bit timeout

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_div_ratio", div_ratio, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_busy",  {31'b0, busy},  32'd0);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Timeout: start bit, then line held low until total_cnt hits 255.
    te.err = 1'b1; te.ratio = last_ratio;
    sb.push_back(te);
    arm();
    @(posedge clk); #1 rx = 1'b0;
    n = 0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); @(negedge clk);
      if (error) begin n = k; break; end
    end
    chk("timeout_cycle", n, 32'd260);
    drain("timeout_drain");

    // Armed with the line already low: no edge until a real 1->0.
    repeat (5) @(posedge clk);
    arm();
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("low_arm_still_busy", {31'b0, busy}, 32'd1);
    #1 rx = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    te = model('{16, 0, -1, 0}, last_ratio);
    sb.push_back(te);
    last_ratio = te.ratio;
    send_bits('{16, 0, -1, 0}, 10);
    repeat (4) @(posedge clk);
    drain("low_arm_drain");

    // Reset after the 3rd edge has been processed: no strobe, outputs cleared.
    run_vec('{12, 0, -1, 0});
    arm();
    send_bits('{7, 0, -1, 0}, 5);
    #1 rx = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_busy",  {31'b0, busy},  32'd0);
    chk("midrst_valid", {31'b0, valid}, 32'd0);
    chk("midrst_error", {31'b0, error}, 32'd0);
    chk("midrst_ratio", div_ratio, 32'd0);
    last_ratio = 32'd0;
    rx = 1'b1;
    #2 rst = 1'b0;
    repeat (10) @(posedge clk);
    chk("midrst_no_strobe", sb.size(), 32'd0);

    // Fresh measurement with a stray i_start pulse in the middle.
    fork
      run_vec('{16, 0, -1, 0});
      begin
        repeat (60) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    join
    chk("rearm_ratio", div_ratio, 32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
